// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants and the lock-state encoding used by the
// sync decoder and the timing generator.
package vga_timing_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int HS_START  = H_DISPLAY + H_FP;
  localparam int HS_END    = HS_START + H_SYNC;

  localparam int V_DISPLAY = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int VS_START  = V_DISPLAY + V_FP;
  localparam int VS_END    = VS_START + V_SYNC;

  localparam bit SYNC_POL    = 1'b0;
  localparam int LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

endpackage

// File: rtl/sync_track.sv
// One sync axis: polarity normalisation, edge detection, position counter
// that realigns on the leading edge, and edge-position mismatch detection.
module sync_track #(
  parameter int TOTAL   = 800,
  parameter int S_START = 656,
  parameter int S_END   = 752,
  parameter bit POL     = 1'b0,
  localparam int CW     = $clog2(TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_i,
  input  logic          step_i,
  input  logic          align_i,
  input  logic          sync_i,
  output logic [CW-1:0] cnt_o,
  output logic          lead_o,
  output logic          wrap_o,
  output logic          mismatch_o
);

  logic          act;
  logic          prev_q, prev_d;
  logic          trail;
  logic          load;
  logic          at_end;
  logic [CW-1:0] cnt_q, cnt_d, cnt_free;

  assign act    = ~(sync_i ^ POL);
  assign lead_o = sample_i & act & ~prev_q;
  assign trail  = sample_i & ~act & prev_q;
  assign load   = lead_o & align_i;
  assign at_end = (cnt_q == CW'(TOTAL - 1));

  // cnt_free is where the counter would be without any realignment; edges are
  // judged against it so a realign never hides the error that caused it.
  assign cnt_free = step_i ? (at_end ? '0 : cnt_q + 1'b1) : cnt_q;
  assign wrap_o   = step_i & at_end & ~load;

  assign mismatch_o = (lead_o & (~align_i | (cnt_free != CW'(S_START)))) |
                      (trail  & (~align_i | (cnt_free != CW'(S_END))));

  assign prev_d = sample_i ? act : prev_q;
  assign cnt_d  = load ? CW'(S_START) : cnt_free;
  assign cnt_o  = cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sync_decode.sv
// Recovers pixel position from incoming hsync/vsync, qualifies the timing
// with a lock FSM and flags every edge that lands off its nominal position.
module sync_decode
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
  parameter int H_FP        = vga_timing_pkg::H_FP,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BP        = vga_timing_pkg::H_BP,
  parameter int V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
  parameter int V_FP        = vga_timing_pkg::V_FP,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BP        = vga_timing_pkg::V_BP,
  parameter bit SYNC_POL    = vga_timing_pkg::SYNC_POL,
  parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES,
  localparam int HT  = H_DISPLAY + H_FP + H_SYNC + H_BP,
  localparam int VT  = V_DISPLAY + V_FP + V_SYNC + V_BP,
  localparam int HSS = H_DISPLAY + H_FP,
  localparam int VSS = V_DISPLAY + V_FP,
  localparam int XW  = $clog2(HT),
  localparam int YW  = $clog2(VT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              hsync_i,
  input  logic              vsync_i,
  output logic [XW-1:0]     x_o,
  output logic [YW-1:0]     y_o,
  output logic              display_o,
  output logic              frame_start_o,
  output logic              locked_o,
  output logic              err_o,
  output lock_state_e       state_o
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          h_lead, h_wrap, h_mis;
  logic          v_lead, v_wrap, v_mis;
  logic          mismatch, active;

  lock_state_e   state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          disp_q, disp_d, fs_q, fs_d, err_q;

  sync_track #(.TOTAL(HT), .S_START(HSS), .S_END(HSS + H_SYNC), .POL(SYNC_POL)) u_h (
    .clk       (clk),
    .rst       (rst),
    .sample_i  (pix_en),
    .step_i    (pix_en),
    .align_i   (1'b1),
    .sync_i    (hsync_i),
    .cnt_o     (h_cnt),
    .lead_o    (h_lead),
    .wrap_o    (h_wrap),
    .mismatch_o(h_mis)
  );

  // Vertical edges are only legal together with an hsync leading edge.
  sync_track #(.TOTAL(VT), .S_START(VSS), .S_END(VSS + V_SYNC), .POL(SYNC_POL)) u_v (
    .clk       (clk),
    .rst       (rst),
    .sample_i  (pix_en),
    .step_i    (h_wrap),
    .align_i   (h_lead),
    .sync_i    (vsync_i),
    .cnt_o     (v_cnt),
    .lead_o    (v_lead),
    .wrap_o    (v_wrap),
    .mismatch_o(v_mis)
  );

  assign mismatch = h_mis | v_mis;

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: if (v_lead && !mismatch) begin
        state_d = TRACK;
        good_d  = '0;
      end
      TRACK: begin
        if (mismatch) begin
          state_d = SEARCH;
        end else if (v_lead) begin
          good_d = good_q + 1'b1;
          if (good_q == GW'(LOCK_FRAMES - 1)) state_d = LOCKED;
        end
      end
      LOCKED: if (mismatch) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  // Both counters reach zero only by wrapping, so a vertical wrap on a strobe
  // is exactly the update that lands on pixel (0,0).
  always_comb begin
    active = (h_cnt < XW'(H_DISPLAY)) && (v_cnt < YW'(V_DISPLAY));
    x_d    = active ? h_cnt : '0;
    y_d    = active ? v_cnt : '0;
    disp_d = active && (state_d == LOCKED);
    fs_d   = v_wrap && (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
      good_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      disp_q  <= 1'b0;
      fs_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      x_q     <= x_d;
      y_q     <= y_d;
      disp_q  <= disp_d;
      fs_q    <= fs_d;
      err_q   <= mismatch;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign display_o     = disp_q;
  assign frame_start_o = fs_q;
  assign err_o         = err_q;
  assign locked_o      = (state_q == LOCKED);
  assign state_o       = state_q;

endmodule

// File: tb/tb_sync_decode.sv
// Drives a reduced-size raster generator into two decoders (active-low and
// active-high sync polarity) and checks both against a frame-index model.
module tb_sync_decode;

  localparam int HD = 20, HFP = 3, HSW = 5, HBP = 4;
  localparam int VD = 12, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HD + HFP + HSW + HBP;
  localparam int VT = VD + VFP + VSW + VBP;
  localparam int HSS = HD + HFP, HSE = HSS + HSW;
  localparam int VSS = VD + VFP, VSE = VSS + VSW;
  localparam int FRAME = HT * VT;
  localparam int VSA = VSS * HT + HSS;
  localparam int VSB = VSE * HT + HSS;
  localparam int LF = 2;
  localparam int XW = $clog2(HT), YW = $clog2(VT);
  localparam int EW = XW + YW + 6;
  localparam int BUDGET = 20000;

  logic clk, rst, pix_en;
  logic hs0, vs0, hs1, vs1;
  logic [XW-1:0] x0, x1;
  logic [YW-1:0] y0, y1;
  logic disp0, disp1, fs0, fs1, lk0, lk1, er0, er1;
  vga_timing_pkg::lock_state_e st0, st1;

  sync_decode #(.H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                .SYNC_POL(1'b0), .LOCK_FRAMES(LF)) dut0 (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_i(hs0), .vsync_i(vs0),
    .x_o(x0), .y_o(y0), .display_o(disp0), .frame_start_o(fs0),
    .locked_o(lk0), .err_o(er0), .state_o(st0));

  sync_decode #(.H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                .SYNC_POL(1'b1), .LOCK_FRAMES(LF)) dut1 (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_i(hs1), .vsync_i(vs1),
    .x_o(x1), .y_o(y1), .display_o(disp1), .frame_start_o(fs1),
    .locked_o(lk1), .err_o(er1), .state_o(st1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int tests = 0, fails = 0, errs_seen = 0;

  // generator + model state
  int idx = 0, vleads = 0, cyc = 0;
  bit hs_act = 0, vs_act = 0;
  logic [XW-1:0] x_e = '0;
  logic [YW-1:0] y_e = '0;
  bit disp_e = 0, fs_e = 0, lk_e = 0, er_e = 0;
  logic [1:0] st_e = 2'd0;
  int pv_idx = 0, pv_vleads = 0;
  bit pv_pe = 0, pv_rst = 0, pv_inj = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input logic [XW-1:0] x, input logic [YW-1:0] y,
                           input logic d, input logic fs, input logic lk, input logic er,
                           input logic [1:0] st, input logic [EW-1:0] e);
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    logic ed, efs, elk, eer;
    logic [1:0] est;
    {ex, ey, ed, efs, elk, eer, est} = e;
    check({tag, ".x"}, int'(x), int'(ex));
    check({tag, ".y"}, int'(y), int'(ey));
    check({tag, ".display"}, int'(d), int'(ed));
    check({tag, ".frame_start"}, int'(fs), int'(efs));
    check({tag, ".locked"}, int'(lk), int'(elk));
    check({tag, ".err"}, int'(er), int'(eer));
    check({tag, ".state"}, int'(st), int'(est));
  endtask

  // compare process: one expected entry per driven cycle
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_dut("pol0", x0, y0, disp0, fs0, lk0, er0, st0, e);
        check_dut("pol1", x1, y1, disp1, fs1, lk1, er1, st1, e);
        if (er0) errs_seen++;
      end
    end
  end

  // hand-computed pins on the cycle just completed
  task automatic pins();
    if (pv_rst) begin
      check("rst.x", int'(x0), 0);
      check("rst.y", int'(y0), 0);
      check("rst.display", int'(disp0), 0);
      check("rst.frame_start", int'(fs0), 0);
      check("rst.locked", int'(lk0), 0);
      check("rst.err", int'(er0), 0);
      check("rst.state", int'(st0), 0);
    end else if (pv_pe) begin
      if (pv_idx == VSA && pv_vleads == LF + 1) check("lock_at_3rd_vs", int'(lk0), 1);
      if (pv_idx == VSA && pv_vleads == LF) check("unlocked_at_2nd_vs", int'(lk0), 0);
      if (pv_idx == 0 && pv_vleads > LF) begin
        check("pix00.frame_start", int'(fs0), 1);
        check("pix00.x", int'(x0), 0);
        check("pix00.y", int'(y0), 0);
        check("pix00.display", int'(disp0), 1);
      end
      if (pv_idx == 371) begin
        check("last_pix.x", int'(x0), 19);
        check("last_pix.y", int'(y0), 11);
      end
      if (pv_idx % HT == 20 && pv_idx / HT < 12) begin
        check("col20.display", int'(disp0), 0);
        check("col20.x", int'(x0), 0);
      end
      if (pv_inj) begin
        check("shift.err", int'(er0), 1);
        check("shift.locked", int'(lk0), 0);
        check("shift.state", int'(st0), 0);
      end
    end
  endtask

  // driver: one cycle of stimulus plus the model's view of the result
  task automatic drive_cycle(input bit r, input bit pe, input bit inj);
    int p, l;
    bit act;
    @(negedge clk);
    pins();
    cyc++;
    rst = r;
    pix_en = pe;
    fs_e = 0;
    er_e = 0;
    if (r) begin
      idx = 0; vleads = 0; hs_act = 0; vs_act = 0;
      x_e = '0; y_e = '0; disp_e = 0;
    end else if (pe) begin
      idx = (idx + (inj ? 2 : 1)) % FRAME;
      p = idx % HT;
      l = idx / HT;
      hs_act = (p >= HSS) && (p < HSE);
      vs_act = (idx >= VSA) && (idx < VSB);
      if (inj) begin
        vleads = 0;
        er_e = 1;
      end
      if (idx == VSA) vleads++;
      act = (p < HD) && (l < VD);
      x_e = act ? XW'(p) : '0;
      y_e = act ? YW'(l) : '0;
      disp_e = act && (vleads > LF);
      fs_e = (idx == 0) && (vleads > LF);
    end
    lk_e = (vleads > LF);
    st_e = (vleads == 0) ? 2'd0 : (vleads <= LF) ? 2'd1 : 2'd2;
    hs0 = ~hs_act; vs0 = ~vs_act;
    hs1 = hs_act;  vs1 = vs_act;
    exp_q.push_back({x_e, y_e, disp_e, fs_e, lk_e, er_e, st_e});
    pv_idx = idx; pv_vleads = vleads; pv_pe = pe; pv_rst = r; pv_inj = inj;
  endtask

  function automatic bit pe_for(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 4) == 0;
    return $urandom_range(0, 2) != 0;
  endfunction

  task automatic run_until(input int target, input int mode);
    int n = 0;
    while (vleads < target && n < BUDGET) begin
      drive_cycle(0, pe_for(mode), 0);
      n++;
    end
    check("vsync_edges_reached", vleads >= target ? 1 : 0, 1);
  endtask

  task automatic inject(input int mode);
    int tl, n;
    tl = $urandom_range(1, VD - 1);
    n = 0;
    while (!(((idx + 1) % HT == HSS - 1) && ((idx + 2) / HT == tl)) && n < BUDGET) begin
      drive_cycle(0, pe_for(mode), 0);
      n++;
    end
    check("inject_point_reached", n < BUDGET ? 1 : 0, 1);
    if (n < BUDGET) drive_cycle(0, 1, 1);
  endtask

  task automatic mid_reset(input int mode);
    int tp, n;
    tp = $urandom_range(1, HD - 1);
    n = 0;
    while (idx % HT != tp && n < BUDGET) begin
      drive_cycle(0, pe_for(mode), 0);
      n++;
    end
    check("reset_point_reached", n < BUDGET ? 1 : 0, 1);
    drive_cycle(1, 1, 0);
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0;
    hs0 = 1'b1; vs0 = 1'b1; hs1 = 1'b0; vs1 = 1'b0;
    repeat (3) drive_cycle(1, 0, 0);
    // strobe every cycle: lock, shifted hsync, relock
    run_until(LF + 2, 0);
    inject(0);
    run_until(LF + 2, 0);
    // reset while locked, then strobe every 4th cycle
    mid_reset(0);
    run_until(LF + 2, 1);
    // random strobe with one shifted hsync
    drive_cycle(1, 1, 0);
    run_until(LF + 2, 2);
    inject(2);
    run_until(LF + 2, 2);
    repeat (3) drive_cycle(0, 0, 0);
    @(posedge clk);
    #2;
    check("err_pulse_total", errs_seen, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_decode.md
SYNC_DECODE -- requirements
Module: sync_decode

Interface
REQ-001 H_DISPLAY, 640, active pixels per line.
REQ-002 H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and pulse widths in pixels.
REQ-003 V_DISPLAY, 480, active lines per frame.
REQ-004 V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and pulse widths in lines.
REQ-005 SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high), shared by hsync and vsync.
REQ-006 LOCK_FRAMES, 2, consecutive error-free frames required to declare lock.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 pix_en  in  1  pixel strobe; all counting and sampling occur only on cycles with pix_en=1.
REQ-010 hsync_i  in  1  incoming horizontal sync, synchronous to clk.
REQ-011 vsync_i  in  1  incoming vertical sync, synchronous to clk.
REQ-012 x_o  out  clog2(H_TOTAL)  recovered column; 0 outside the active area.
REQ-013 y_o  out  clog2(V_TOTAL)  recovered line; 0 outside the active area.
REQ-014 display_o  out  1  locked and inside the active area.
REQ-015 frame_start_o  out  1  one-cycle pulse at pixel (0,0) while locked.
REQ-016 locked_o  out  1  lock FSM is in LOCKED.
REQ-017 err_o  out  1  one-cycle pulse on any timing mismatch.

Function
REQ-018 H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP; HS_START = H_DISPLAY+H_FP; HS_END = HS_START+H_SYNC; V_TOTAL, VS_START and VS_END are defined the same way.
REQ-019 Active sync = input XNOR SYNC_POL; the previous active value is held per axis and updated only on pix_en.
REQ-020 hcnt: on a pix_en cycle with an hsync leading edge, hcnt <= HS_START; otherwise on pix_en, hcnt <= hcnt+1, wrapping from H_TOTAL-1 to 0.
REQ-021 vcnt: on a vsync leading edge coincident with an hsync leading edge, vcnt <= VS_START; otherwise vcnt advances (wrapping from V_TOTAL-1 to 0) when hcnt wraps; a vsync edge with no hsync edge in the same cycle is an error.
REQ-022 Mismatch conditions: an hsync leading edge where the free-running next hcnt != HS_START; an hsync trailing edge where next hcnt != HS_END; the vertical equivalents against VS_START/VS_END.
REQ-023 Lock FSM states: SEARCH, TRACK, LOCKED. SEARCH->TRACK on the first vsync leading edge and clears the good-frame count.
REQ-024 In TRACK, the good-frame count increments on each vsync leading edge with no mismatch since the previous one; a mismatch returns the FSM to SEARCH; TRACK->LOCKED when the count reaches LOCK_FRAMES.
REQ-025 In LOCKED, any mismatch -> SEARCH, locked_o falls on the next cycle, and counters realign on the offending edge.
REQ-026 err_o pulses for one cycle per mismatch in every state; simultaneous h and v mismatches produce a single pulse.
REQ-027 x_o, y_o, display_o and frame_start_o are registered, with 1 clk latency after the pix_en cycle that sampled the pixel.
REQ-028 display_o = locked AND hcnt<H_DISPLAY AND vcnt<V_DISPLAY.
REQ-029 frame_start_o = locked AND pix_en AND hcnt==0 AND vcnt==0 after the update.
REQ-030 With pix_en=0, all state holds and all pulse outputs are 0.

Reset
REQ-031 rst: hcnt=0, vcnt=0, FSM=SEARCH, good-frame count=0, previous-sync registers=inactive.
REQ-032 rst: x_o=0, y_o=0, display_o=0, frame_start_o=0, locked_o=0, err_o=0.
REQ-033 rst asserted mid-frame takes priority over pix_en; decoding resumes from SEARCH.

Structure
REQ-034 Timing localparams (totals, start/end points) and the lock-state enum SHALL be in the shared package vga_timing_pkg, also used by the generator side.
REQ-035 A sub-module sync_track SHALL implement one axis (polarity, edge detect, counter, mismatch) and be instantiated twice, once per axis.

Verification
REQ-036 Bench drives the generator in 640x480 timing, pix_en every cycle -> locked_o=1 after the 3rd vsync leading edge (SEARCH->TRACK, +2 good frames); err_o never pulses.
REQ-037 Once locked, pixel (0,0) -> frame_start_o=1 one cycle later with x_o=0, y_o=0, display_o=1; pixel (639,479) -> x_o=639, y_o=479; pixel (640,y) -> display_o=0, x_o=0.
REQ-038 Once locked, one hsync leading edge is shifted 1 pixel early -> a single err_o pulse, locked_o=0, hcnt=HS_START at that edge; relock after 3 further vsync edges.
REQ-039 pix_en asserted every 4th cycle -> same lock and positions as REQ-036/037, with pulses only on strobe cycles.
REQ-040 SYNC_POL=1 with inverted syncs -> identical results to REQ-036.
REQ-041 rst asserted for one cycle mid-line while locked -> all outputs 0 on the next cycle; FSM in SEARCH; relock as in REQ-036.
